// File: rtl/signed_add_sat_pipe.sv
// Two-stage signed adder with optional saturation, valid/ready handshakes
// on both sides and a sticky/counted overflow statistic.
module signed_add_sat_pipe #(
    parameter int W     = 8,
    parameter bit SAT   = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     sum,
    output logic             overflow,
    input  logic             clr_stats,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [W-1:0] SUM_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SUM_MIN = {1'b1, {(W-1){1'b0}}};

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             out_xfer;
    logic             s2_load;
    logic [W-1:0]     raw_sum;
    logic             raw_ovf;
    logic [W-1:0]     res_sum;

    // Handshake decode: S2 frees up when its result leaves this cycle,
    // which in turn lets S1 advance and accept a new pair.
    always_comb begin
        out_xfer = s2_valid_q && out_ready;
        s2_load  = !s2_valid_q || out_xfer;
        in_ready = !s1_valid_q || s2_load;
    end

    // Adder on the S1 operands; overflow when like-signed operands give an
    // unlike-signed result. Saturation picks the rail from operand sign.
    always_comb begin
        raw_sum = a_q + b_q;
        raw_ovf = (a_q[W-1] == b_q[W-1]) && (raw_sum[W-1] != a_q[W-1]);
        res_sum = raw_sum;
        if (SAT && raw_ovf) begin
            res_sum = a_q[W-1] ? SUM_MIN : SUM_MAX;
        end
    end

    // Next-state for both pipeline stages; data only loads with a real
    // transaction so held outputs stay untouched.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        ovf_d      = ovf_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d = a;
                b_d = b;
            end
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d = res_sum;
                ovf_d = raw_ovf;
            end
        end
    end

    // Overflow statistics count delivered results only; clear has priority.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr_stats) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (out_xfer && ovf_q) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset empties the pipeline and clears statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs come straight from the S2 and statistics registers.
    always_comb begin
        out_valid  = s2_valid_q;
        sum        = sum_q;
        overflow   = ovf_q;
        ovf_sticky = sticky_q;
        ovf_count  = cnt_q;
    end

endmodule

// File: tb/tb_signed_add_sat_pipe.sv
// Bench: a wrapping and a saturating instance (W=4, CNT_W=2) share stimulus;
// a scoreboard queue holds predicted results for both.
module tb_signed_add_sat_pipe;

    localparam int W = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [W-1:0] s_wrap;
        logic [W-1:0] s_sat;
        logic         ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  a, b;
    logic          out_ready;
    logic          clr_stats;

    logic          in_ready0, out_valid0, ovf0, sticky0;
    logic [W-1:0]  sum0;
    logic [CW-1:0] cnt0;
    logic          in_ready1, out_valid1, ovf1, sticky1;
    logic [W-1:0]  sum1;
    logic [CW-1:0] cnt1;

    int            n_vec = 0;
    int            n_err = 0;
    exp_t          sb_q[$];
    logic [CW-1:0] exp_cnt;
    logic          exp_sticky;

    always #5 clk = ~clk;

    signed_add_sat_pipe #(.W(W), .SAT(1'b0), .CNT_W(CW)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .overflow(ovf0), .clr_stats(clr_stats),
        .ovf_sticky(sticky0), .ovf_count(cnt0));

    signed_add_sat_pipe #(.W(W), .SAT(1'b1), .CNT_W(CW)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .overflow(ovf1), .clr_stats(clr_stats),
        .ovf_sticky(sticky1), .ovf_count(cnt1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference in integer arithmetic: range check decides overflow.
    function automatic exp_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int          s;
        logic [31:0] sv;
        s  = int'($signed(x)) + int'($signed(y));
        sv = s;
        e.ovf    = (s > 7) || (s < -8);
        e.s_wrap = sv[W-1:0];
        e.s_sat  = (s > 7) ? 4'b0111 : ((s < -8) ? 4'b1000 : sv[W-1:0]);
        return e;
    endfunction

    // Scoreboard + statistics model, evaluated mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            exp_cnt    = '0;
            exp_sticky = 1'b0;
        end else begin
            chk("cnt_wrap", 32'(cnt0), 32'(exp_cnt));
            chk("cnt_sat", 32'(cnt1), 32'(exp_cnt));
            chk("sticky_wrap", 32'(sticky0), 32'(exp_sticky));
            chk("sticky_sat", 32'(sticky1), 32'(exp_sticky));
            chk("valid_match", 32'(out_valid1), 32'(out_valid0));
            e = '0;
            if (out_valid0 && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 32'(1), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("sum_wrap", 32'(sum0), 32'(e.s_wrap));
                    chk("ovf_wrap", 32'(ovf0), 32'(e.ovf));
                    chk("sum_sat", 32'(sum1), 32'(e.s_sat));
                    chk("ovf_sat", 32'(ovf1), 32'(e.ovf));
                end
            end
            if (clr_stats) begin
                exp_cnt    = '0;
                exp_sticky = 1'b0;
            end else if (out_valid0 && out_ready && e.ovf) begin
                exp_sticky = 1'b1;
                if (exp_cnt != 2'b11) exp_cnt = exp_cnt + 2'd1;
            end
            if (in_valid && in_ready0) sb_q.push_back(ref_add(a, b));
        end
    end

    // Present one pair and hold it until accepted; returns one edge after acceptance.
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        a        = aa;
        b        = bb;
        @(negedge clk);
        while (!in_ready0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) chk("accept_timeout", 32'(1), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    // Single pair into an idle pipe with out_ready high: fixed two-edge latency.
    task automatic direct(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] e_wrap, input logic [W-1:0] e_sat, input logic e_ovf);
        int w;
        out_ready = 1'b1;
        send(aa, bb, w);
        chk({tag, "_lat1"}, 32'(out_valid0), 32'(0));
        step();
        chk({tag, "_lat2"}, 32'(out_valid0), 32'(1));
        chk({tag, "_sum_wrap"}, 32'(sum0), 32'(e_wrap));
        chk({tag, "_sum_sat"}, 32'(sum1), 32'(e_sat));
        chk({tag, "_ovf_wrap"}, 32'(ovf0), 32'(e_ovf));
        chk({tag, "_ovf_sat"}, 32'(ovf1), 32'(e_ovf));
        step();
    endtask

    initial begin
        int w, acc, sent;
        logic [W-1:0] ops_a[4];
        logic [W-1:0] ops_b[4];

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        out_ready = 1'b1; clr_stats = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready0), 32'(1));
        chk("rst_out_valid", 32'(out_valid0), 32'(0));
        chk("rst_sum", 32'(sum0), 32'(0));
        chk("rst_cnt", 32'(cnt0), 32'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // First edge after release accepts without waiting.
        send(4'd2, 4'd3, w);
        chk("first_accept_wait", 32'(w), 32'(0));
        repeat (3) step();

        direct("p7p1", 4'd7, 4'd1, 4'b1000, 4'd7, 1'b1);
        direct("m8m1", 4'b1000, 4'b1111, 4'd7, 4'b1000, 1'b1);
        direct("p3m5", 4'd3, 4'b1011, 4'b1110, 4'b1110, 1'b0);
        direct("m3m4", 4'b1101, 4'b1100, 4'b1001, 4'b1001, 1'b0);

        // Backpressure: four pairs offered with out_ready low.
        ops_a = '{4'd1, 4'd5, 4'b1010, 4'd6};
        ops_b = '{4'd2, 4'd4, 4'b1001, 4'b1110};
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = ops_a[acc]; b = ops_b[acc];
            @(negedge clk);
            if (in_ready0) acc++;
            step();
        end
        chk("bp_accepted", 32'(acc), 32'(2));
        chk("bp_in_ready", 32'(in_ready0), 32'(0));
        chk("bp_hold_sum", 32'(sum0), 32'(4'd3));
        out_ready = 1'b1;
        while (acc < 4) begin
            send(ops_a[acc], ops_b[acc], w);
            acc++;
        end
        repeat (4) step();
        chk("bp_drained", 32'(sb_q.size()), 32'(0));

        // Overflow counter saturation and clear priority.
        clr_stats = 1'b1; step(); clr_stats = 1'b0;
        for (int i = 0; i < 5; i++) send(4'd7, 4'd1, w);
        repeat (3) step();
        chk("stat_cnt_sat", 32'(cnt0), 32'(3));
        chk("stat_sticky", 32'(sticky1), 32'(1));
        send(4'd7, 4'd1, w);
        step();
        chk("stat6_out_valid", 32'(out_valid0), 32'(1));
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("stat_clr_cnt", 32'(cnt0), 32'(0));
        chk("stat_clr_sticky", 32'(sticky0), 32'(0));

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(4'd1, 4'd1, w);
        send(4'd2, 4'd2, w);
        chk("mid_out_valid_pre", 32'(out_valid0), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid0), 32'(0));
        chk("mid_rst_sum", 32'(sum0), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready0), 32'(1));
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_stale", 32'(out_valid0), 32'(0));
        end

        // Random traffic against the model.
        sent = 0;
        while (sent < 10000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 63) == 0);
            if (!in_valid && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
            acc = int'(in_valid && in_ready0);
            step();
            if (acc != 0) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; clr_stats = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        chk("rand_drained", 32'(sb_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
